// File: rtl/arbitro_mux_quatro.sv
// Round-robin arbiter for a shared 4:1 word mux. It grants A..D in bounded
// bursts and drives the mux selects; the data path itself is purely combinational.
module arbitro_mux_quatro #(
  parameter int LARGURA    = 4,
  parameter int RAJADA_MAX = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [3:0]         req,
  input  logic [LARGURA-1:0] inA,
  input  logic [LARGURA-1:0] inB,
  input  logic [LARGURA-1:0] inC,
  input  logic [LARGURA-1:0] inD,
  input  logic               pronto,
  output logic [3:0]         grant,
  output logic               chave0,
  output logic               chave1,
  output logic [LARGURA-1:0] outX,
  output logic               outValido
);

  localparam int CW = $clog2(RAJADA_MAX + 1);
  localparam logic [CW-1:0] ULTIMO = CW'(RAJADA_MAX - 1);

  typedef enum logic {OCIOSO, CONCEDIDO} estadoT;

  // FSM state is kept in this named signal so checkers can bind to it.
  estadoT        estado;
  logic [1:0]    ponteiro;
  logic [1:0]    dono;
  logic [CW-1:0] contagem;
  logic [1:0]    escolhido;
  logic [1:0]    candidato;
  logic          achou;

  // Handshake: a beat moves only in a cycle where outValido && pronto.
  // outValido depends on the owner's req in the same cycle, never on pronto.
  logic transfer;
  assign outValido = (estado == CONCEDIDO) && req[dono];
  assign transfer  = outValido && pronto;

  // First requester at or after the pointer, wrapping modulo 4.
  always_comb begin
    escolhido = ponteiro;
    candidato = ponteiro;
    achou     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      candidato = ponteiro + 2'(i);
      if (!achou && req[candidato]) begin
        escolhido = candidato;
        achou     = 1'b1;
      end
    end
  end

  always_comb begin
    case ({chave1, chave0})
      2'd0:    outX = inA;
      2'd1:    outX = inB;
      2'd2:    outX = inC;
      default: outX = inD;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado   <= OCIOSO;
      grant    <= 4'b0000;
      chave0   <= 1'b0;
      chave1   <= 1'b0;
      ponteiro <= 2'd0;
      dono     <= 2'd0;
      contagem <= '0;
    end else begin
      case (estado)
        OCIOSO: begin
          if (req != 4'b0000) begin
            dono     <= escolhido;
            grant    <= 4'b0001 << escolhido;
            chave0   <= escolhido[0];
            chave1   <= escolhido[1];
            contagem <= '0;
            estado   <= CONCEDIDO;
          end
        end
        CONCEDIDO: begin
          // Selects are left untouched on release so outX keeps the last owner.
          if (!req[dono] || (transfer && contagem == ULTIMO)) begin
            estado   <= OCIOSO;
            grant    <= 4'b0000;
            ponteiro <= dono + 2'd1;
            contagem <= '0;
          end else if (transfer) begin
            contagem <= contagem + CW'(1);
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_mux_quatro.sv
// Directed bench for arbitro_mux_quatro: a table of per-cycle vectors with
// hand-computed outputs, followed by a few hand-written multi-cycle sequences.
module tb_arbitro_mux_quatro;

  localparam int LARGURA = 4;

  logic               clock;
  logic               reset;
  logic [3:0]         req;
  logic [LARGURA-1:0] inA, inB, inC, inD;
  logic               pronto;
  logic [3:0]         grant;
  logic               chave0, chave1;
  logic [LARGURA-1:0] outX;
  logic               outValido;

  int checks = 0;
  int errors = 0;

  arbitro_mux_quatro #(.LARGURA(LARGURA), .RAJADA_MAX(4)) dut (
    .clock(clock), .reset(reset), .req(req),
    .inA(inA), .inB(inB), .inC(inC), .inD(inD),
    .pronto(pronto), .grant(grant), .chave0(chave0), .chave1(chave1),
    .outX(outX), .outValido(outValido)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       pronto;
    logic [3:0] expGrant;
    logic [1:0] expSel;
    logic       expValido;
  } vetorT;

  vetorT tabela[$];

  task automatic addRows(input int n, input logic rst, input logic [3:0] r,
                         input logic p, input logic [3:0] g, input logic [1:0] s,
                         input logic v);
    vetorT linha;
    linha = '{rst, r, p, g, s, v};
    for (int i = 0; i < n; i++) tabela.push_back(linha);
  endtask

  task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    checks++;
    if (atual !== esperado) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nome, atual, esperado, $time);
    end
  endtask

  function automatic logic [LARGURA-1:0] dadoDe(input logic [1:0] s);
    case (s)
      2'd0:    return 4'h3;
      2'd1:    return 4'hA;
      2'd2:    return 4'h5;
      default: return 4'hC;
    endcase
  endfunction

  task automatic checkSaidas(input string tag, input logic [3:0] g, input logic [1:0] s,
                             input logic v);
    check({tag, " grant"}, 32'(grant), 32'(g));
    check({tag, " sel"}, 32'({chave1, chave0}), 32'(s));
    check({tag, " outValido"}, 32'(outValido), 32'(v));
    check({tag, " outX"}, 32'(outX), 32'(dadoDe(s)));
    check({tag, " onehot"}, 32'($countones(grant) <= 1), 32'd1);
    if (grant != 4'b0000)
      check({tag, " sel_vs_grant"}, 32'(4'b0001 << {chave1, chave0}), 32'(grant));
  endtask

  task automatic proximoCiclo();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int ciclos;
    inA = 4'h3; inB = 4'hA; inC = 4'h5; inD = 4'hC;
    reset = 1'b1; req = 4'b1111; pronto = 1'b1;

    // reset held for two edges with every requester active
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkSaidas("reset", 4'b0000, 2'd0, 1'b0);
    proximoCiclo();
    reset = 1'b0;

    // continuous requests: A,B,C,D,A with 4 beats and one bubble each
    addRows(1, 0, 4'b1111, 1, 4'b0000, 2'd0, 0);
    addRows(4, 0, 4'b1111, 1, 4'b0001, 2'd0, 1);
    addRows(1, 0, 4'b1111, 1, 4'b0000, 2'd0, 0);
    addRows(4, 0, 4'b1111, 1, 4'b0010, 2'd1, 1);
    addRows(1, 0, 4'b1111, 1, 4'b0000, 2'd1, 0);
    addRows(4, 0, 4'b1111, 1, 4'b0100, 2'd2, 1);
    addRows(1, 0, 4'b1111, 1, 4'b0000, 2'd2, 0);
    addRows(4, 0, 4'b1111, 1, 4'b1000, 2'd3, 1);
    addRows(1, 0, 4'b1111, 1, 4'b0000, 2'd3, 0);
    addRows(1, 0, 4'b0000, 1, 4'b0001, 2'd0, 0);
    addRows(1, 0, 4'b0000, 1, 4'b0000, 2'd0, 0);
    // B alone: 4 beats, bubble, re-grant of B
    addRows(1, 0, 4'b0010, 1, 4'b0000, 2'd0, 0);
    addRows(4, 0, 4'b0010, 1, 4'b0010, 2'd1, 1);
    addRows(1, 0, 4'b0010, 1, 4'b0000, 2'd1, 0);
    addRows(1, 0, 4'b0010, 1, 4'b0010, 2'd1, 1);
    addRows(1, 0, 4'b0000, 1, 4'b0010, 2'd1, 0);
    addRows(1, 0, 4'b0000, 1, 4'b0000, 2'd1, 0);
    // C with backpressure after beat 1; release after 4 accepted beats
    addRows(1, 0, 4'b0100, 1, 4'b0000, 2'd1, 0);
    addRows(1, 0, 4'b0100, 1, 4'b0100, 2'd2, 1);
    addRows(3, 0, 4'b0100, 0, 4'b0100, 2'd2, 1);
    addRows(3, 0, 4'b0100, 1, 4'b0100, 2'd2, 1);
    addRows(1, 0, 4'b0000, 1, 4'b0000, 2'd2, 0);
    // D drops after 2 beats; pointer wraps so A wins over D
    addRows(1, 0, 4'b1000, 1, 4'b0000, 2'd2, 0);
    addRows(2, 0, 4'b1000, 1, 4'b1000, 2'd3, 1);
    addRows(1, 0, 4'b0000, 1, 4'b1000, 2'd3, 0);
    addRows(1, 0, 4'b1001, 1, 4'b0000, 2'd3, 0);
    addRows(1, 0, 4'b1001, 1, 4'b0001, 2'd0, 1);
    addRows(1, 0, 4'b0000, 1, 4'b0001, 2'd0, 0);
    addRows(1, 0, 4'b0000, 1, 4'b0000, 2'd0, 0);
    // reset mid-burst of C; pointer back to 0 so C beats D
    addRows(1, 0, 4'b0100, 1, 4'b0000, 2'd0, 0);
    addRows(2, 0, 4'b0100, 1, 4'b0100, 2'd2, 1);
    addRows(1, 1, 4'b0100, 1, 4'b0100, 2'd2, 1);
    addRows(1, 0, 4'b1100, 1, 4'b0000, 2'd0, 0);
    addRows(1, 0, 4'b1100, 1, 4'b0100, 2'd2, 1);
    addRows(1, 0, 4'b0000, 1, 4'b0100, 2'd2, 0);
    addRows(1, 0, 4'b0000, 1, 4'b0000, 2'd2, 0);

    foreach (tabela[i]) begin
      reset  = tabela[i].rst;
      req    = tabela[i].req;
      pronto = tabela[i].pronto;
      @(negedge clock);
      checkSaidas($sformatf("vec%0d", i), tabela[i].expGrant, tabela[i].expSel,
                  tabela[i].expValido);
      proximoCiclo();
    end

    // request-to-first-beat latency, bounded wait
    req = 4'b0001; pronto = 1'b0; ciclos = 0;
    while (!outValido && ciclos < 8) begin
      proximoCiclo();
      ciclos++;
    end
    check("latency", 32'(ciclos), 32'd1);

    // long stall: grant held with no timeout
    repeat (5) proximoCiclo();
    check("stall grant", 32'(grant), 32'h1);
    check("stall valid", 32'(outValido), 32'd1);
    check("stall outX", 32'(outX), 32'h3);

    // 3 accepted beats keep the grant, the 4th releases it
    pronto = 1'b1;
    repeat (3) proximoCiclo();
    check("beat3 grant", 32'(grant), 32'h1);
    proximoCiclo();
    check("burst end grant", 32'(grant), 32'h0);
    check("burst end valid", 32'(outValido), 32'd0);
    req = 4'b0000;
    proximoCiclo();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arbitro_mux_quatro.md
Name: arbitro_mux_quatro

Overview:
Round-robin arbiter and sequencer that shares one 4:1 word-wide multiplexer datapath between four requesters (A, B, C, D).
- Owns and drives the select lines chave0/chave1 of the shared mux.
- Grants one requester at a time for a bounded burst of beats, under a valid/ready handshake toward the downstream consumer.
- Sits between the requester-side data sources and the single shared output bus.

Parameters:
LARGURA, 4, width of each data input and of outX
RAJADA_MAX, 4, maximum beats transferred per grant before forced release (legal range 1..15)

Ports:
clock  input  1  single system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
req  input  4  request lines, bit0=A, bit1=B, bit2=C, bit3=D
inA  input  LARGURA  data word from requester A
inB  input  LARGURA  data word from requester B
inC  input  LARGURA  data word from requester C
inD  input  LARGURA  data word from requester D
pronto  input  1  downstream ready
grant  output  4  one-hot registered grant, same bit order as req
chave0  output  1  mux select LSB (registered)
chave1  output  1  mux select MSB (registered)
outX  output  LARGURA  selected data word
outValido  output  1  outX carries a valid beat

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are named clock and reset.
- Select encoding: index = {chave1, chave0}; 0 = A, 1 = B, 2 = C, 3 = D.
- outX is a per-bit 4:1 combinational selection of inA..inD by {chave1, chave0}. There is no register on the data path.
- Reset (sampled high at an edge):
  - state = OCIOSO, grant = 4'b0000, chave0 = chave1 = 0, pointer = 0, beat count = 0.
  - outValido = 0. outX follows inA.
  - Reset has priority over everything, including mid-burst.
- Internal state:
  - 2-bit pointer: first candidate in the round-robin search.
  - 2-bit owner index.
  - Beat counter, $clog2(RAJADA_MAX+1) bits.
- FSM states: OCIOSO, CONCEDIDO.
- OCIOSO:
  - grant = 0, outValido = 0.
  - If req != 0 at edge k: search pointer, pointer+1, ... (mod 4) and take the first set bit as owner.
  - At edge k: grant = onehot(owner), {chave1, chave0} = owner, count = 0, go to CONCEDIDO.
  - If req == 0, stay in OCIOSO; selects hold their last value.
- CONCEDIDO:
  - outValido = req[owner] (combinational).
  - Transfer = outValido && pronto.
  - On transfer with count < RAJADA_MAX-1: count++.
  - On transfer with count == RAJADA_MAX-1: release.
  - If req[owner] == 0 at an edge: release. outValido is already 0 in that cycle.
  - pronto == 0 with req[owner] == 1: hold grant, selects and count unchanged (backpressure, no timeout).
  - Release: next state OCIOSO, grant = 0, pointer = owner+1 (mod 4, wrap 3 -> 0), count = 0.
  - Selects keep the owner value through OCIOSO until the next grant.
- Latency and bubbles:
  - Request to first valid beat: 1 cycle.
  - Exactly one idle (bubble) cycle between consecutive grants, even when requests are continuous.
- Requests from non-owners during CONCEDIDO are ignored until the next OCIOSO evaluation. No preemption.
- Requester protocol (not enforced by the block): hold req and data stable while outValido && !pronto.
- grant is always one-hot or zero, and {chave1, chave0} equals the grant index whenever grant != 0. The bench checks both.

Test Plan:
1. reset=1 for 2 edges with req=4'b1111 -> grant=0, chave0=chave1=0, outValido=0. After reset falls, first grant is A (pointer 0).
2. req=4'b0010, inB=4'hA, pronto=1, RAJADA_MAX=4 -> one cycle after req: grant=0010, {chave1,chave0}=01, outValido=1, outX=4'hA for 4 cycles. Then 1 idle cycle with outValido=0. Then B is re-granted.
3. req=4'b1111, pronto=1 -> grant sequence A,B,C,D,A. Each grant is 4 valid beats followed by 1 bubble; selects go 00, 01, 10, 11, 00.
4. C granted (inC=4'h5), pronto=0 for 3 cycles after beat 1 -> grant=0100, outValido=1, outX=4'h5 held. Count does not advance. Release occurs exactly after 4 accepted beats total.
5. D granted, req[3] drops after 2 beats, then req=4'b1001 -> outValido=0 in the drop cycle, OCIOSO next cycle. Next grant is A (pointer wrapped 3 -> 0), selects = 00.
6. Reset asserted while C granted with count=2, then req=4'b1100 -> after reset all outputs are 0 and pointer=0. Next grant is C (search A, B, C from pointer 0), not D.
